// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer.
//   - opcode constants (4-bit command opcodes)
//   - 6-bit Hack ALU control words {zx,nx,zy,ny,f,no}
//   - controller state enum
package alu_seq_pkg;

  localparam logic [3:0] OP_ZERO = 4'd0;
  localparam logic [3:0] OP_ONE  = 4'd1;
  localparam logic [3:0] OP_X    = 4'd2;
  localparam logic [3:0] OP_Y    = 4'd3;
  localparam logic [3:0] OP_NOTX = 4'd4;
  localparam logic [3:0] OP_NEGX = 4'd5;
  localparam logic [3:0] OP_XINC = 4'd6;
  localparam logic [3:0] OP_XDEC = 4'd7;
  localparam logic [3:0] OP_ADD  = 4'd8;
  localparam logic [3:0] OP_SUB  = 4'd9;
  localparam logic [3:0] OP_AND  = 4'd10;
  localparam logic [3:0] OP_OR   = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  localparam logic [5:0] CTRL_ZERO = 6'b101010;
  localparam logic [5:0] CTRL_ONE  = 6'b111111;
  localparam logic [5:0] CTRL_X    = 6'b001100;
  localparam logic [5:0] CTRL_Y    = 6'b110000;
  localparam logic [5:0] CTRL_NOTX = 6'b001101;
  localparam logic [5:0] CTRL_NEGX = 6'b001111;
  localparam logic [5:0] CTRL_XINC = 6'b011111;
  localparam logic [5:0] CTRL_XDEC = 6'b001110;
  localparam logic [5:0] CTRL_ADD  = 6'b000010;
  localparam logic [5:0] CTRL_SUB  = 6'b010011;
  localparam logic [5:0] CTRL_AND  = 6'b000000;
  localparam logic [5:0] CTRL_OR   = 6'b010101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL_ACC,
    S_MUL_DBL,
    S_DONE
  } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/response channel bundle for alu_sequencer.
//   cmd_*  : valid/ready request channel (opcode + two operands)
//   rsp_*  : valid/ready response channel (result, zero/negative flags, error)
// master = requester side, slave = the sequencer.
interface alu_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zr;
  logic             rsp_ng;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zr, rsp_ng, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_zr, rsp_ng, rsp_err
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder.
//   op      in  4  command opcode
//   ctrl    out 6  {zx,nx,zy,ny,f,no}; MUL yields the ADD word used by its loop
//   illegal out 1  opcode 13..15
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output logic [5:0] ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (op)
      OP_ZERO: ctrl = CTRL_ZERO;
      OP_ONE:  ctrl = CTRL_ONE;
      OP_X:    ctrl = CTRL_X;
      OP_Y:    ctrl = CTRL_Y;
      OP_NOTX: ctrl = CTRL_NOTX;
      OP_NEGX: ctrl = CTRL_NEGX;
      OP_XINC: ctrl = CTRL_XINC;
      OP_XDEC: ctrl = CTRL_XDEC;
      OP_ADD:  ctrl = CTRL_ADD;
      OP_SUB:  ctrl = CTRL_SUB;
      OP_AND:  ctrl = CTRL_AND;
      OP_OR:   ctrl = CTRL_OR;
      OP_MUL:  ctrl = CTRL_ADD;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command-level controller for an external combinational Hack-style ALU.
//   clk, rst_n          clock / async active-low reset
//   bus (slave)         cmd valid/ready channel in, rsp valid/ready channel out
//   busy                controller not idle
//   alu_x, alu_y        ALU operands (0 when ALU unused)
//   alu_zx..alu_no      ALU control bits (0 when ALU unused)
//   alu_out/zr/ng       ALU result and flags
// Single-cycle ops use one ALU evaluation; MUL is a 2*WIDTH-cycle shift-add
// loop that reuses the ALU adder for both the accumulate and the doubling.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_sequencer_if.slave   bus,
  output logic             busy,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_zr_q, rsp_ng_q, rsp_err_q;

  logic [3:0]       dec_op;
  logic [5:0]       dec_ctrl;
  logic             dec_illegal;
  logic [5:0]       ctrl;

  // One decoder serves both the accept decision (incoming opcode) and the
  // EXEC control word (latched opcode).
  assign dec_op = (state_q == S_IDLE) ? bus.cmd_op : op_q;

  alu_op_decode u_dec (
    .op      (dec_op),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (dec_illegal)              state_d = S_DONE;
          else if (bus.cmd_op == OP_MUL) state_d = S_MUL_ACC;
          else                          state_d = S_EXEC;
        end
      end
      S_EXEC:    state_d = S_DONE;
      S_MUL_ACC: state_d = S_MUL_DBL;
      S_MUL_DBL: state_d = (cnt_q == LAST) ? S_DONE : S_MUL_ACC;
      S_DONE:    if (bus.rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_x = '0;
    alu_y = '0;
    ctrl  = '0;
    case (state_q)
      S_EXEC: begin
        alu_x = a_q;
        alu_y = b_q;
        ctrl  = dec_ctrl;
      end
      S_MUL_ACC: begin
        alu_x = acc_q;
        alu_y = mcand_q;
        ctrl  = CTRL_ADD;
      end
      S_MUL_DBL: begin
        alu_x = mcand_q;
        alu_y = mcand_q;
        ctrl  = CTRL_ADD;
      end
      default: ;
    endcase
  end

  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_zr_q   <= 1'b0;
      rsp_ng_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q     <= bus.cmd_op;
            a_q      <= bus.cmd_a;
            b_q      <= bus.cmd_b;
            acc_q    <= '0;
            mcand_q  <= bus.cmd_a;
            mplier_q <= bus.cmd_b;
            cnt_q    <= '0;
            rsp_err_q <= dec_illegal;
            if (dec_illegal) begin
              rsp_data_q <= '0;
              rsp_zr_q   <= 1'b0;
              rsp_ng_q   <= 1'b0;
            end
          end
        end
        S_EXEC: begin
          rsp_data_q <= alu_out;
          rsp_zr_q   <= alu_zr;
          rsp_ng_q   <= alu_ng;
        end
        S_MUL_ACC: begin
          if (mplier_q[0]) acc_q <= alu_out;
        end
        S_MUL_DBL: begin
          mcand_q  <= alu_out;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // acc already holds the final sum: the last accumulate happened
          // in the preceding MUL_ACC cycle.
          if (cnt_q == LAST) begin
            rsp_data_q <= acc_q;
            rsp_zr_q   <= (acc_q == '0);
            rsp_ng_q   <= acc_q[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zr    = rsp_zr_q;
  assign bus.rsp_ng    = rsp_ng_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(W)) bus ();

  logic         busy;
  logic [W-1:0] alu_x, alu_y, alu_out;
  logic         alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;

  alu_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .busy    (busy),
    .alu_x   (alu_x),
    .alu_y   (alu_y),
    .alu_zx  (alu_zx),
    .alu_nx  (alu_nx),
    .alu_zy  (alu_zy),
    .alu_ny  (alu_ny),
    .alu_f   (alu_f),
    .alu_no  (alu_no),
    .alu_out (alu_out),
    .alu_zr  (alu_zr),
    .alu_ng  (alu_ng)
  );

  // Hack ALU attached to the controller
  logic [W-1:0] hx, hy, ho;
  always_comb begin
    hx = alu_zx ? '0 : alu_x;
    if (alu_nx) hx = ~hx;
    hy = alu_zy ? '0 : alu_y;
    if (alu_ny) hy = ~hy;
    ho = alu_f ? (hx + hy) : (hx & hy);
    if (alu_no) ho = ~ho;
    alu_out = ho;
    alu_zr  = (ho == '0);
    alu_ng  = ho[W-1];
  end

  typedef struct {
    logic [W-1:0] data;
    logic         zr;
    logic         ng;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic bp    = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the opcode meaning
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] r;
    e.err = 1'b0;
    case (op)
      4'd0:  r = '0;
      4'd1:  r = 1;
      4'd2:  r = a;
      4'd3:  r = b;
      4'd4:  r = ~a;
      4'd5:  r = -a;
      4'd6:  r = a + 1;
      4'd7:  r = a - 1;
      4'd8:  r = a + b;
      4'd9:  r = a - b;
      4'd10: r = a & b;
      4'd11: r = a | b;
      4'd12: r = a * b;
      default: begin r = '0; e.err = 1'b1; end
    endcase
    e.data = r;
    e.zr   = e.err ? 1'b0 : (r == '0);
    e.ng   = e.err ? 1'b0 : r[W-1];
    e.lat  = (op == 4'd12) ? 2 * W + 1 : ((op > 4'd12) ? 1 : 2);
    e.acc  = 0;
    return e;
  endfunction

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    while (!bus.cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      chk("accept_timeout", 64'd1, 64'd0);
      bus.cmd_valid = 1'b0;
      return;
    end
    e     = model(op, a, b);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = W'($urandom);
    bus.cmd_b     = W'($urandom);
  endtask

  // response consumer with random stalls
  always @(posedge clk) begin
    #1;
    bus.rsp_ready = bp ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  // monitor / scoreboard
  logic         seen = 1'b0;
  exp_t         cur;
  logic [W+2:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (bus.rsp_valid) begin
      if (!seen) begin
        seen = 1'b1;
        held = {bus.rsp_data, bus.rsp_zr, bus.rsp_ng, bus.rsp_err};
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          cur = sb.pop_front();
          chk("rsp_data", 64'(bus.rsp_data), 64'(cur.data));
          chk("rsp_zr",   64'(bus.rsp_zr),   64'(cur.zr));
          chk("rsp_ng",   64'(bus.rsp_ng),   64'(cur.ng));
          chk("rsp_err",  64'(bus.rsp_err),  64'(cur.err));
          chk("latency",  64'(cyc - cur.acc), 64'(cur.lat));
        end
      end else begin
        chk("rsp_hold", 64'({bus.rsp_data, bus.rsp_zr, bus.rsp_ng, bus.rsp_err}), 64'(held));
      end
      chk("done_busy_ready", 64'({busy, bus.cmd_ready}), 64'b10);
      if (bus.rsp_ready) seen = 1'b0;
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rsp"}, 64'({bus.rsp_valid, bus.rsp_data, bus.rsp_zr, bus.rsp_ng, bus.rsp_err, busy}), 64'd0);
    chk({tag, "_alu"}, 64'({alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 64'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   c0;
    logic [3:0] op;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;

    #12;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 64'(bus.cmd_ready), 64'd1);

    // directed cases
    send(4'd8, 16'd5, 16'd7);
    send(4'd9, 16'd3, 16'd5);
    send(4'd0, 16'h1234, 16'h5678);
    send(4'd12, 16'd300, 16'd200);
    send(4'd12, 16'hFFFF, 16'hFFFF);
    send(4'd13, 16'h1111, 16'h2222);
    send(4'd8, 16'h7FFF, 16'd1);
    send(4'd5, 16'h8000, 16'd0);
    wait_idle();

    // backpressure: hold response, pulse cmd_valid while not ready
    bp = 1'b1;
    @(posedge clk);
    #2;
    send(4'd11, 16'hA0A0, 16'h0505);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("bp_rsp_timeout", 64'd1, 64'd0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      bus.cmd_valid = ~bus.cmd_valid;
      bus.cmd_op    = 4'd8;
      bus.cmd_a     = W'($urandom);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bp = 1'b0;
    wait_idle();

    // randomized traffic
    repeat (80) begin
      op = ($urandom_range(0, 9) == 0) ? 4'd12 : 4'($urandom_range(0, 15));
      send(op, W'($urandom), ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom));
    end
    wait_idle();

    // reset during multiply iteration 8
    send(4'd12, 16'd300, 16'd200);
    c0 = sb[$].acc;
    while (cyc < c0 + 17) @(negedge clk);
    chk("busy_before_abort", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("abort");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_abort", 64'(bus.cmd_ready), 64'd1);
    repeat (8) begin
      @(negedge clk);
      chk("no_rsp_after_abort", 64'({bus.rsp_valid, busy}), 64'd0);
    end
    send(4'd8, 16'd40, 16'd2);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-level controller for the combinational Hack-style ALU (zx/nx/zy/ny/f/no control). Accepts operation requests over a valid/ready command channel, drives the ALU operands and six control bits, captures result and zr/ng flags, and returns them over a valid/ready response channel. Single-cycle ALU functions map directly to one ALU evaluation. Multiply is sequenced as a 2·WIDTH-cycle shift-add loop through the same ALU, so the datapath needs no dedicated multiplier.

## Interface
- WIDTH, 16, operand/result width; must match the ALU instance
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept (IDLE only)
- cmd_op  in  4  opcode (see Operation)
- cmd_a, cmd_b  in  WIDTH  operands
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  WIDTH  result
- rsp_zr, rsp_ng  out  1  result zero / result negative (MSB)
- rsp_err  out  1  illegal opcode
- busy  out  1  state != IDLE
- alu_x, alu_y  out  WIDTH  ALU operands
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1  ALU control
- alu_out  in  WIDTH  ALU result
- alu_zr, alu_ng  in  1  ALU flags

## Operation
- Opcodes (zx nx zy ny f no): 0 ZERO 101010, 1 ONE 111111, 2 X 001100, 3 Y 110000, 4 NOTX 001101, 5 NEGX 001111, 6 XINC 011111, 7 XDEC 001110, 8 ADD 000010, 9 SUB(x−y) 010011, 10 AND 000000, 11 OR 010101, 12 MUL, 13–15 illegal.
- States: IDLE, EXEC, MUL_ACC, MUL_DBL, DONE.
- IDLE: cmd_ready=1. On cmd_valid: latch op/a/b; op 0–11 → EXEC; op 12 → MUL_ACC with acc=0, mcand=a, mplier=b, cnt=0; op 13–15 → DONE with rsp_err=1, rsp_data=0, flags 0.
- EXEC: alu_x=a, alu_y=b, controls per opcode; register alu_out/alu_zr/alu_ng into rsp_*; → DONE.
- MUL_ACC: ALU ADD, x=acc, y=mcand; if mplier[0] acc←alu_out; → MUL_DBL.
- MUL_DBL: ALU ADD, x=mcand, y=mcand; mcand←alu_out; mplier←mplier>>1; cnt←cnt+1; if cnt==WIDTH−1 → DONE with rsp_data=acc, rsp_zr=(acc==0), rsp_ng=acc[WIDTH−1]; else → MUL_ACC.
- MUL result: low WIDTH bits of a·b (unsigned == two's-complement low bits); overflow discarded, no flag. Always full WIDTH iterations, no early exit.
- DONE: rsp_valid=1; rsp_* held stable until rsp_valid&&rsp_ready, then → IDLE.
- ALU outputs outside EXEC/MUL_*: operands 0, all controls 0.

## Timing
- Reset (async assert, sync release): state IDLE; cmd_ready=1 after release; rsp_valid, rsp_data, rsp_zr, rsp_ng, rsp_err, busy, all alu_* outputs = 0.
- Accept edge = cycle 0. ALU op: EXEC cycle 1, rsp_valid from cycle 2. MUL: rsp_valid from cycle 2·WIDTH+1 (33 for WIDTH=16). Illegal: rsp_valid from cycle 1.
- rsp handshake in cycle n → IDLE at n+1; cmd_ready=1 in n+1. No command overlap; throughput one command per (latency+1) cycles minimum.
- cmd_valid ignored while cmd_ready=0; operands sampled only on accept edge.
- Reset mid-operation aborts; no response emitted, partial state discarded.
- ALU is combinational; alu_out sampled same cycle as drive.

## Structure
- Package alu_seq_pkg: opcode constants, 6-bit control encodings, state enum.
- Sub-module alu_op_decode: combinational opcode → {zx,nx,zy,ny,f,no} plus illegal flag.
- Testbench instantiates the ALU and connects alu_* ports.

## Test plan
- ADD a=5 b=7 → rsp_data=12, zr=0, ng=0, err=0, rsp_valid at cycle 2.
- SUB a=3 b=5 → rsp_data=0xFFFE, ng=1; ZERO → data 0, zr=1.
- MUL a=300 b=200 → rsp_data=0xEA60, ng=1, zr=0, rsp_valid at cycle 33; MUL a=0xFFFF b=0xFFFF → 0x0001.
- Illegal op 13 → rsp_err=1, data 0, rsp_valid at cycle 1; next ADD unaffected.
- Backpressure: rsp_ready low 5 cycles after rsp_valid → data/flags stable, cmd_ready=0, cmd_valid pulses ignored.
- rst_n asserted during MUL iteration 8 → all outputs 0 immediately; after release cmd_ready=1, no rsp_valid.
